dac_write_arbiter: RTL and testbench

- Shares the dual-channel, time-multiplexed DAC write port between two requesters: requester 0 is the PS command path, requester 1 is the loop filter/ramp datapath.
- Round-robin arbitration grants one requester at a time.
- Each granted write runs through a fixed SETUP/STROBE/HOLD sequence on dac_dat_o/dac_sel_o/dac_wrt_o.
- Keeps a shadow of the last code written to each channel and reports it for PS readback.

---
 rtl/dac_write_arbiter.sv | 131 +++++++++++++
 tb/tb_dac_write_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_arbiter.sv
// Round-robin arbiter for the shared, time-multiplexed dual-channel DAC write
// port. Requester 0 is the PS command path and requester 1 is the loop
// filter/ramp datapath. Each granted write runs a SETUP/STROBE/HOLD sequence.
// The block also keeps a shadow of the last code strobed into each channel.
module dac_write_arbiter #(
  parameter int                        DAC_DATA_WIDTH = 14,
  parameter int                        HOLD_CYCLES    = 1,
  parameter logic [DAC_DATA_WIDTH-1:0] RESET_CODE     = 14'h2000,
  parameter int                        CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic                      req0_valid_i,
  output logic                      req0_ready_o,
  input  logic                      req0_chan_i,
  input  logic [DAC_DATA_WIDTH-1:0] req0_data_i,
  input  logic                      req1_valid_i,
  output logic                      req1_ready_o,
  input  logic                      req1_chan_i,
  input  logic [DAC_DATA_WIDTH-1:0] req1_data_i,
  output logic [DAC_DATA_WIDTH-1:0] dac_dat_o,
  output logic                      dac_sel_o,
  output logic                      dac_wrt_o,
  output logic                      busy_o,
  output logic                      grant_o,
  output logic [DAC_DATA_WIDTH-1:0] chan_a_o,
  output logic [DAC_DATA_WIDTH-1:0] chan_b_o,
  output logic [CNT_WIDTH-1:0]      wr_count_o
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  // Loaded on entry to HOLD; HOLD ends on the cycle the counter reads zero.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [3:0]                hold_q, hold_d;
  logic [DAC_DATA_WIDTH-1:0] dat_q, dat_d;
  logic                      sel_q, sel_d;
  logic                      grant_q, grant_d;
  logic [DAC_DATA_WIDTH-1:0] a_q, a_d;
  logic [DAC_DATA_WIDTH-1:0] b_q, b_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic idle;
  logic win;

  // Arbitration: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    idle         = (state_q == IDLE);
    win          = (req0_valid_i && req1_valid_i) ? ~grant_q : ~req0_valid_i;
    req0_ready_o = idle & req0_valid_i & ~win;
    req1_ready_o = idle & req1_valid_i & win;
  end

  // Next-state logic: accept in IDLE, shadow/count update on leaving STROBE.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req0_ready_o || req1_ready_o) begin
          state_d = SETUP;
          grant_d = win;
          dat_d   = win ? req1_data_i : req0_data_i;
          sel_d   = win ? req1_chan_i : req0_chan_i;
        end
      end
      SETUP: begin
        state_d = STROBE;
      end
      STROBE: begin
        if (sel_q) b_d = dat_q;
        else       a_d = dat_q;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (HOLD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          hold_d  = HOLD_LAST;
        end
      end
      HOLD: begin
        if (hold_q == 4'd0) state_d = IDLE;
        else                hold_d  = hold_q - 4'd1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any write in flight.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= 4'd0;
      dat_q   <= RESET_CODE;
      sel_q   <= 1'b0;
      grant_q <= 1'b1;
      a_q     <= RESET_CODE;
      b_q     <= RESET_CODE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dac_dat_o  = dat_q;
  assign dac_sel_o  = sel_q;
  assign dac_wrt_o  = (state_q == STROBE);
  assign busy_o     = (state_q != IDLE);
  assign grant_o    = grant_q;
  assign chan_a_o   = a_q;
  assign chan_b_o   = b_q;
  assign wr_count_o = cnt_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Bench for dac_write_arbiter. Instance u0 uses default parameters; instance
// u1 uses HOLD_CYCLES = 0 and an 8-bit counter so counter wrap and the
// 3-cycle write period can be reached in a short run.
module tb_dac_write_arbiter;
  localparam int W = 14;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic         rst;
  logic         v0 [2];
  logic         v1 [2];
  logic         c0 [2];
  logic         c1 [2];
  logic [W-1:0] d0 [2];
  logic [W-1:0] d1 [2];
  logic         r0 [2];
  logic         r1 [2];
  logic         sel [2];
  logic         wrt [2];
  logic         busy [2];
  logic         gnt [2];
  logic [W-1:0] dat [2];
  logic [W-1:0] cha [2];
  logic [W-1:0] chb [2];
  logic [15:0]  cnt0;
  logic [7:0]   cnt1;

  int n_chk  = 0;
  int n_fail = 0;

  dac_write_arbiter u0 (
    .clk(clk), .rst_i(rst),
    .req0_valid_i(v0[0]), .req0_ready_o(r0[0]), .req0_chan_i(c0[0]), .req0_data_i(d0[0]),
    .req1_valid_i(v1[0]), .req1_ready_o(r1[0]), .req1_chan_i(c1[0]), .req1_data_i(d1[0]),
    .dac_dat_o(dat[0]), .dac_sel_o(sel[0]), .dac_wrt_o(wrt[0]), .busy_o(busy[0]),
    .grant_o(gnt[0]), .chan_a_o(cha[0]), .chan_b_o(chb[0]), .wr_count_o(cnt0)
  );

  dac_write_arbiter #(.HOLD_CYCLES(0), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst_i(rst),
    .req0_valid_i(v0[1]), .req0_ready_o(r0[1]), .req0_chan_i(c0[1]), .req0_data_i(d0[1]),
    .req1_valid_i(v1[1]), .req1_ready_o(r1[1]), .req1_chan_i(c1[1]), .req1_data_i(d1[1]),
    .dac_dat_o(dat[1]), .dac_sel_o(sel[1]), .dac_wrt_o(wrt[1]), .busy_o(busy[1]),
    .grant_o(gnt[1]), .chan_a_o(cha[1]), .chan_b_o(chb[1]), .wr_count_o(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each write is tracked by its age in cycles since accept.
  // Age 0 = idle, age 2 = strobe cycle, writes last 3 + HOLD_CYCLES cycles.
  int           m_age [2];
  logic [W-1:0] m_dat [2];
  logic         m_sel [2];
  logic         m_gnt [2];
  logic [W-1:0] m_a [2];
  logic [W-1:0] m_b [2];
  int           m_cnt [2];

  always @(negedge clk) begin : model
    logic w, e0, e1;
    int   hold, modv;
    logic [31:0] cnt_act;
    for (int i = 0; i < 2; i++) begin
      hold = (i == 0) ? 1 : 0;
      modv = (i == 0) ? 65536 : 256;
      cnt_act = (i == 0) ? 32'(cnt0) : 32'(cnt1);
      if (rst) begin
        m_age[i] = 0;
        m_dat[i] = 14'h2000;
        m_sel[i] = 1'b0;
        m_gnt[i] = 1'b1;
        m_a[i]   = 14'h2000;
        m_b[i]   = 14'h2000;
        m_cnt[i] = 0;
      end
      w  = (v0[i] && v1[i]) ? !m_gnt[i] : !v0[i];
      e0 = (m_age[i] == 0) && v0[i] && !w;
      e1 = (m_age[i] == 0) && v1[i] && w;
      chk($sformatf("u%0d.ready0", i), 32'(r0[i]), 32'(e0));
      chk($sformatf("u%0d.ready1", i), 32'(r1[i]), 32'(e1));
      chk($sformatf("u%0d.dac_dat", i), 32'(dat[i]), 32'(m_dat[i]));
      chk($sformatf("u%0d.dac_sel", i), 32'(sel[i]), 32'(m_sel[i]));
      chk($sformatf("u%0d.dac_wrt", i), 32'(wrt[i]), 32'(m_age[i] == 2));
      chk($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(m_age[i] != 0));
      chk($sformatf("u%0d.grant", i), 32'(gnt[i]), 32'(m_gnt[i]));
      chk($sformatf("u%0d.chan_a", i), 32'(cha[i]), 32'(m_a[i]));
      chk($sformatf("u%0d.chan_b", i), 32'(chb[i]), 32'(m_b[i]));
      chk($sformatf("u%0d.wr_count", i), cnt_act, 32'(m_cnt[i]));
      if (!rst) begin
        if (m_age[i] == 2) begin
          if (m_sel[i]) m_b[i] = m_dat[i];
          else          m_a[i] = m_dat[i];
          m_cnt[i] = (m_cnt[i] + 1) % modv;
        end
        if (m_age[i] == 0) begin
          if (e0) begin
            m_dat[i] = d0[i]; m_sel[i] = c0[i]; m_gnt[i] = 1'b0; m_age[i] = 1;
          end else if (e1) begin
            m_dat[i] = d1[i]; m_sel[i] = c1[i]; m_gnt[i] = 1'b1; m_age[i] = 1;
          end
        end else begin
          m_age[i] = (m_age[i] >= 2 + hold) ? 0 : m_age[i] + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int acc_k [$];
  int acc_g [$];
  int acc, cyc, last_wrt, nsp;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0; c0[i] = 1'b0; c1[i] = 1'b0;
      d0[i] = '0;   d1[i] = '0;
    end
    repeat (3) step();
    rst = 1'b0;
    step(); #1;

    // Reset values with no requests.
    chk("rst.dat", 32'(dat[0]), 32'h2000);
    chk("rst.chan_a", 32'(cha[0]), 32'h2000);
    chk("rst.chan_b", 32'(chb[0]), 32'h2000);
    chk("rst.wrt", 32'(wrt[0]), 32'h0);
    chk("rst.busy", 32'(busy[0]), 32'h0);
    chk("rst.count", 32'(cnt0), 32'h0);
    chk("rst.grant", 32'(gnt[0]), 32'h1);

    // Single req0 write, channel A, 0x1234.
    step();
    v0[0] = 1'b1; c0[0] = 1'b0; d0[0] = 14'h1234;
    #1;
    chk("w0.T.ready0", 32'(r0[0]), 32'h1);
    chk("w0.T.busy", 32'(busy[0]), 32'h0);
    step(); v0[0] = 1'b0; #1;
    chk("w0.T1.dat", 32'(dat[0]), 32'h1234);
    chk("w0.T1.sel", 32'(sel[0]), 32'h0);
    chk("w0.T1.wrt", 32'(wrt[0]), 32'h0);
    chk("w0.T1.busy", 32'(busy[0]), 32'h1);
    step(); #1;
    chk("w0.T2.wrt", 32'(wrt[0]), 32'h1);
    step(); #1;
    chk("w0.T3.wrt", 32'(wrt[0]), 32'h0);
    chk("w0.T3.busy", 32'(busy[0]), 32'h1);
    chk("w0.T3.chan_a", 32'(cha[0]), 32'h1234);
    chk("w0.T3.count", 32'(cnt0), 32'h1);
    step(); #1;
    chk("w0.T4.busy", 32'(busy[0]), 32'h0);

    // req1 write to channel B aborted by reset during STROBE.
    step();
    v1[0] = 1'b1; c1[0] = 1'b1; d1[0] = 14'h1111;
    #1;
    chk("ab.ready1", 32'(r1[0]), 32'h1);
    step(); v1[0] = 1'b0;
    step(); #1;
    chk("ab.strobe", 32'(wrt[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("ab.dat", 32'(dat[0]), 32'h2000);
    chk("ab.sel", 32'(sel[0]), 32'h0);
    chk("ab.wrt", 32'(wrt[0]), 32'h0);
    chk("ab.busy", 32'(busy[0]), 32'h0);
    chk("ab.chan_a", 32'(cha[0]), 32'h2000);
    chk("ab.chan_b", 32'(chb[0]), 32'h2000);
    chk("ab.count", 32'(cnt0), 32'h0);
    chk("ab.grant", 32'(gnt[0]), 32'h1);
    step(); step();
    rst = 1'b0;

    // Both requesters held valid: grants alternate starting with req0.
    v0[0] = 1'b1; c0[0] = 1'b0; d0[0] = 14'h0AAA;
    v1[0] = 1'b1; c1[0] = 1'b1; d1[0] = 14'h3555;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("rr.ready_excl", 32'(r0[0] && r1[0]), 32'h0);
      if (r0[0]) begin acc_k.push_back(k); acc_g.push_back(0); end
      if (r1[0]) begin acc_k.push_back(k); acc_g.push_back(1); end
      step();
    end
    v0[0] = 1'b0; v1[0] = 1'b0;
    chk("rr.n_accepts", 32'(acc_k.size()), 32'd4);
    for (int j = 0; j < acc_k.size() && j < 4; j++) begin
      chk($sformatf("rr.accept_cycle%0d", j), 32'(acc_k[j]), 32'(4 * j));
      chk($sformatf("rr.accept_grant%0d", j), 32'(acc_g[j]), 32'(j % 2));
    end
    step(); #1;
    chk("rr.chan_a", 32'(cha[0]), 32'h0AAA);
    chk("rr.chan_b", 32'(chb[0]), 32'h3555);
    chk("rr.count", 32'(cnt0), 32'd4);

    // Lone req0 write leaves grant at 0.
    step();
    v0[0] = 1'b1; c0[0] = 1'b0; d0[0] = 14'h0123;
    #1;
    chk("g0.ready0", 32'(r0[0]), 32'h1);
    step(); v0[0] = 1'b0;
    repeat (3) step();

    // Contest with grant 0: req1 wins, req0 drops and never writes.
    v0[0] = 1'b1; c0[0] = 1'b0; d0[0] = 14'h0777;
    v1[0] = 1'b1; c1[0] = 1'b1; d1[0] = 14'h0BBB;
    #1;
    chk("ct.grant_before", 32'(gnt[0]), 32'h0);
    chk("ct.ready1", 32'(r1[0]), 32'h1);
    chk("ct.ready0", 32'(r0[0]), 32'h0);
    step(); v0[0] = 1'b0; v1[0] = 1'b0;
    repeat (5) step();
    #1;
    chk("ct.count", 32'(cnt0), 32'd6);
    chk("ct.chan_a", 32'(cha[0]), 32'h0123);
    chk("ct.chan_b", 32'(chb[0]), 32'h0BBB);
    chk("ct.busy", 32'(busy[0]), 32'h0);

    // u1: 256 back-to-back writes with no HOLD wrap the 8-bit counter.
    step();
    v0[1] = 1'b1; c0[1] = 1'b0;
    acc = 0; cyc = 0; last_wrt = -1; nsp = 0;
    while (acc < 256 && cyc < 2000) begin
      d0[1] = 14'(acc);
      #1;
      if (wrt[1]) begin
        if (last_wrt >= 0 && nsp < 5) begin
          chk("wrap.wrt_spacing", 32'(cyc - last_wrt), 32'd3);
          nsp++;
        end
        last_wrt = cyc;
      end
      if (r0[1]) begin
        acc++;
        if (acc == 256) chk("wrap.count_ff", 32'(cnt1), 32'hFF);
      end
      step();
      cyc++;
    end
    v0[1] = 1'b0;
    chk("wrap.no_timeout", 32'(cyc < 2000), 32'h1);
    repeat (4) step();
    #1;
    chk("wrap.count_zero", 32'(cnt1), 32'h0);
    chk("wrap.chan_a", 32'(cha[1]), 32'd255);
    chk("wrap.busy", 32'(busy[1]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
